// File: rtl/elevator_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : elev_pkg
// Brief    : Shared state encoding and default sizing for elevator_scheduler.
// Revision : 1.0
// ============================================================================
package elev_pkg;

  localparam int ELEV_NFLOORS       = 4;
  localparam int ELEV_TRAVEL_CYCLES = 2;
  localparam int ELEV_DOOR_CYCLES   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DOOR = 2'd1,
    MOVE = 2'd2
  } elev_state_t;

endpackage
`default_nettype wire

// File: rtl/elevator_scheduler_req_scan.sv
`default_nettype none
// ============================================================================
// Module   : elev_req_scan
// Brief    : Classifies latched calls relative to a floor: here/above/below,
//            plus the side the car is currently heading towards.
// Revision : 1.0
// ============================================================================
module elev_req_scan
  import elev_pkg::*;
#(
  parameter  int NFLOORS = ELEV_NFLOORS,
  localparam int FLOOR_W = $clog2(NFLOORS)
) (
  input  logic [NFLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0] floor_i,
  input  logic               dir_up_i,
  output logic               here_o,
  output logic               above_o,
  output logic               below_o,
  output logic               ahead_o
);

  always_comb begin
    here_o  = 1'b0;
    above_o = 1'b0;
    below_o = 1'b0;
    for (int i = 0; i < NFLOORS; i++) begin
      if (i == int'(floor_i)) begin
        here_o = pending_i[i];
      end else if (i > int'(floor_i)) begin
        above_o = above_o | pending_i[i];
      end else begin
        below_o = below_o | pending_i[i];
      end
    end
  end

  assign ahead_o = dir_up_i ? above_o : below_o;

endmodule
`default_nettype wire

// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Brief    : Single-car SCAN scheduler with call latch, travel/door timers.
//            Optional macro ELEV_DOOR_HOLD_EN adds the door_hold input.
// Revision : 1.0
// ============================================================================
module elevator_scheduler
  import elev_pkg::*;
#(
  parameter  int NFLOORS       = ELEV_NFLOORS,
  parameter  int TRAVEL_CYCLES = ELEV_TRAVEL_CYCLES,
  parameter  int DOOR_CYCLES   = ELEV_DOOR_CYCLES,
  localparam int FLOOR_W       = $clog2(NFLOORS)
) (
  input  logic               clk_2,
  input  logic               reset,
  input  logic [NFLOORS-1:0] call,
`ifdef ELEV_DOOR_HOLD_EN
  input  logic               door_hold,
`endif
  output logic [FLOOR_W-1:0] floor,
  output logic               dir_up,
  output logic               moving,
  output logic               door_open,
  output logic [NFLOORS-1:0] pending
);

  localparam int TCNT_W = $clog2(TRAVEL_CYCLES + 1);
  localparam int DCNT_W = $clog2(DOOR_CYCLES + 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DOOR_CYCLES - 1);

  elev_state_t        state_q, state_d;
  logic [FLOOR_W-1:0] floor_q;
  logic               dir_up_q, dir_up_d;
  logic               moving_q, door_open_q;
  logic [NFLOORS-1:0] pending_q, pending_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [DCNT_W-1:0]  dcnt_q, dcnt_d;

  logic               w_hold;
  logic               w_step;
  logic [FLOOR_W-1:0] w_eval_floor;
  logic               w_scan_here, w_above, w_below, w_ahead;
  logic               w_here;
  logic               w_eval, w_skip_here;

`ifdef ELEV_DOOR_HOLD_EN
  assign w_hold = door_hold;
`else
  assign w_hold = 1'b0;
`endif

  // Decisions on the last travel count are taken for the floor being entered.
  assign w_step       = (state_q == MOVE) && (tcnt_q == TCNT_LAST);
  assign w_eval_floor = !w_step  ? floor_q :
                        dir_up_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

  elev_req_scan #(
    .NFLOORS (NFLOORS)
  ) u_scan (
    .pending_i (pending_q),
    .floor_i   (w_eval_floor),
    .dir_up_i  (dir_up_q),
    .here_o    (w_scan_here),
    .above_o   (w_above),
    .below_o   (w_below),
    .ahead_o   (w_ahead)
  );

  assign w_here = w_scan_here | call[w_eval_floor];

  always_comb begin
    state_d     = state_q;
    dir_up_d    = dir_up_q;
    pending_d   = pending_q | call;
    tcnt_d      = tcnt_q;
    dcnt_d      = dcnt_q;
    w_eval      = 1'b0;
    w_skip_here = 1'b0;

    case (state_q)
      IDLE: w_eval = 1'b1;
      MOVE: begin
        if (w_step) w_eval = 1'b1;
        else        tcnt_d = tcnt_q + TCNT_W'(1);
      end
      DOOR: begin
        // A call at the open door is served by the stop itself.
        pending_d[floor_q] = pending_q[floor_q];
        if (call[floor_q] || w_hold) begin
          dcnt_d = '0;
        end else if (dcnt_q == DCNT_LAST) begin
          w_eval      = 1'b1;
          w_skip_here = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (w_eval) begin
      if (w_here && !w_skip_here) begin
        state_d                 = DOOR;
        dcnt_d                  = '0;
        pending_d[w_eval_floor] = 1'b0;
      end else if (w_ahead) begin
        state_d = MOVE;
        tcnt_d  = '0;
      end else if (w_above || w_below) begin
        state_d  = MOVE;
        dir_up_d = !dir_up_q;
        tcnt_d   = '0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      floor_q     <= '0;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
      pending_q   <= '0;
      tcnt_q      <= '0;
      dcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      floor_q     <= w_eval_floor;
      dir_up_q    <= dir_up_d;
      moving_q    <= (state_d == MOVE);
      door_open_q <= (state_d == DOOR);
      pending_q   <= pending_d;
      tcnt_q      <= tcnt_d;
      dcnt_q      <= dcnt_d;
    end
  end

  assign floor     = floor_q;
  assign dir_up    = dir_up_q;
  assign moving    = moving_q;
  assign door_open = door_open_q;
  assign pending   = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            random calls against a remaining-time behavioural model.
// Revision : 1.0
// ============================================================================
module tb_elevator_scheduler;

  localparam int NF = 4;
  localparam int TR = 2;
  localparam int DC = 2;

  logic          clk_2;
  logic          reset;
  logic [NF-1:0] call;
  logic          door_hold;
  logic [1:0]    floor;
  logic          dir_up;
  logic          moving;
  logic          door_open;
  logic [NF-1:0] pending;

  int checks;
  int errors;

  elevator_scheduler #(
    .NFLOORS       (NF),
    .TRAVEL_CYCLES (TR),
    .DOOR_CYCLES   (DC)
  ) dut (
    .clk_2     (clk_2),
    .reset     (reset),
    .call      (call),
`ifdef ELEV_DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .floor     (floor),
    .dir_up    (dir_up),
    .moving    (moving),
    .door_open (door_open),
    .pending   (pending)
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- reference model: remaining-time view of the car -------
  int  m_floor;
  int  m_left;
  bit  m_up;
  bit  m_moving;
  bit  m_door;
  bit  m_pend [NF];

  task automatic m_reset();
    m_floor = 0; m_left = 0; m_up = 1'b1; m_moving = 1'b0; m_door = 1'b0;
    for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
  endtask

  task automatic m_step(input logic [NF-1:0] c, input bit h);
    bit old_p [NF];
    bit ev, skip, here;
    int n_above, n_below;
    for (int i = 0; i < NF; i++) old_p[i] = m_pend[i];
    for (int i = 0; i < NF; i++) if (c[i]) m_pend[i] = 1'b1;
    ev = 1'b0; skip = 1'b0;
    if (m_door) begin
      m_pend[m_floor] = old_p[m_floor];
      if (c[m_floor] || h) m_left = DC;
      else if (m_left == 1) begin ev = 1'b1; skip = 1'b1; end
      else m_left = m_left - 1;
    end else if (m_moving) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_floor = m_up ? m_floor + 1 : m_floor - 1;
        ev = 1'b1;
      end
    end else begin
      ev = 1'b1;
    end
    if (ev) begin
      n_above = 0; n_below = 0;
      for (int i = 0; i < NF; i++) begin
        if (old_p[i] && i > m_floor) n_above++;
        if (old_p[i] && i < m_floor) n_below++;
      end
      here = !skip && (old_p[m_floor] || c[m_floor]);
      m_door = 1'b0; m_moving = 1'b0;
      if (here) begin
        m_door = 1'b1; m_left = DC; m_pend[m_floor] = 1'b0;
      end else if ((m_up && n_above > 0) || (!m_up && n_below > 0)) begin
        m_moving = 1'b1; m_left = TR;
      end else if (n_above + n_below > 0) begin
        m_up = !m_up; m_moving = 1'b1; m_left = TR;
      end
    end
  endtask

  function automatic logic [8:0] m_outs();
    logic [NF-1:0] p;
    for (int i = 0; i < NF; i++) p[i] = m_pend[i];
    return {2'(m_floor), m_up, m_moving, m_door, p};
  endfunction

  // ---------------- helpers -----------------------------------------------
  function automatic logic [8:0] outs();
    return {floor, dir_up, moving, door_open, pending};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2);
    #1;
  endtask

  task automatic reset_dut();
    call = '0; door_hold = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk_2);
    #1 reset = 1'b1;
    m_reset();
  endtask

  // {call, floor, dir_up, moving, door_open, pending} after each edge
  typedef struct packed {
    logic [3:0] call;
    logic [1:0] floor;
    logic       up;
    logic       mov;
    logic       door;
    logic [3:0] pend;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    int  n;
    int  nstops;
    int  stops [4];
    bit  got, prev;
    logic [NF-1:0] rc;

    checks = 0; errors = 0;
    call = '0; door_hold = 1'b0; reset = 1'b1;

    vecs[0]  = '{4'b0001, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[1]  = '{4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[2]  = '{4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{4'b1000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b1000};
    vecs[4]  = '{4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[5]  = '{4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[6]  = '{4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[7]  = '{4'b0000, 2'd1, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[8]  = '{4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[9]  = '{4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, 4'b1000};
    vecs[10] = '{4'b0000, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[11] = '{4'b0000, 2'd3, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[12] = '{4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[13] = '{4'b0001, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[14] = '{4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001};
    vecs[15] = '{4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 4'b0001};
    vecs[16] = '{4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 4'b0001};

    // ---- reset values and vector table ----
    reset_dut();
    check("reset_state", 32'(outs()), 32'(9'b00_1_0_0_0000));
    for (int i = 0; i < NV; i++) begin
      call = vecs[i].call;
      tick();
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({vecs[i].floor, vecs[i].up, vecs[i].mov, vecs[i].door, vecs[i].pend}));
    end
    call = '0;

    // ---- SCAN: stops at 1 then 3, then reversal back to 0 ----
    reset_dut();
    call = 4'b1010;
    tick();
    call = '0;
    nstops = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (door_open && !prev && nstops < 4) begin stops[nstops] = int'(floor); nstops++; end
      prev = door_open;
      if (!door_open && !moving && nstops >= 2) break;
    end
    check("scan_nstops", 32'(nstops), 32'd2);
    check("scan_stop0", 32'(stops[0]), 32'd1);
    check("scan_stop1", 32'(stops[1]), 32'd3);
    call = 4'b0001;
    tick();
    call = '0;
    tick();
    check("rev_moving", 32'(moving), 32'd1);
    check("rev_dir", 32'(dir_up), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (door_open) got = 1'b1;
    end
    check("rev_reach", 32'(got), 32'd1);
    check("rev_floor", 32'(floor), 32'd0);
    check("rev_pending", 32'(pending), 32'd0);

    // ---- door absorbs a call at its own floor ----
    reset_dut();
    call = 4'b0100;
    tick();
    call = '0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (door_open) got = 1'b1;
    end
    check("abs_reach", 32'(got), 32'd1);
    check("abs_floor", 32'(floor), 32'd2);
    call = 4'b0100;
    n = 1;
    tick();
    call = '0;
    if (door_open) n++;
    check("abs_pending", 32'(pending), 32'd0);
    for (int k = 0; k < 10 && door_open; k++) begin
      tick();
      if (door_open) n++;
    end
    check("abs_open_cycles", 32'(n), 32'd3);

    // ---- asynchronous reset while travelling between floors 1 and 2 ----
    reset_dut();
    call = 4'b1000;
    tick();
    call = '0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (moving && floor == 2'd1) got = 1'b1;
    end
    check("rst_reach", 32'(got), 32'd1);
    reset = 1'b0;
    #1;
    check("rst_async", 32'(outs()), 32'(9'b00_1_0_0_0000));
    tick();
    #1 reset = 1'b1;
    tick();
    tick();
    check("rst_idle", 32'(outs()), 32'(9'b00_1_0_0_0000));

`ifdef ELEV_DOOR_HOLD_EN
    // ---- door hold keeps the door open, then normal close time ----
    reset_dut();
    call = 4'b0001;
    tick();
    call = '0;
    check("hold_open", 32'(door_open), 32'd1);
    door_hold = 1'b1;
    n = 1;
    repeat (5) begin
      tick();
      if (door_open) n++;
    end
    door_hold = 1'b0;
    for (int k = 0; k < 10 && door_open; k++) begin
      tick();
      if (door_open) n++;
    end
    check("hold_open_cycles", 32'(n), 32'd7);
`endif

    // ---- random calls against the model ----
    reset_dut();
    for (int cyc = 0; cyc < 3000 && errors < 50; cyc++) begin
      rc = '0;
      for (int b = 0; b < NF; b++) if ($urandom_range(0, 9) == 0) rc[b] = 1'b1;
      call = rc;
`ifdef ELEV_DOOR_HOLD_EN
      door_hold = ($urandom_range(0, 15) == 0);
`endif
      @(posedge clk_2);
      m_step(call, door_hold);
      #1;
      check($sformatf("rand%0d", cyc), 32'(outs()), 32'(m_outs()));
      check("exclusive", 32'(moving & door_open), 32'd0);
    end
    call = '0;
    door_hold = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
